// File: rtl/uartcon_rx.sv
// UART 8N1 receiver driven by the oversample clock level from the baud divider.
// Everything runs on clk; rate_clk rising edges are detected and used as ticks.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | line idle, waiting for a tick that sees rxd low
// START      | counting to the centre of the start bit, rejecting glitches
// DATA       | sampling eight data bits at bit centres, LSB first
// STOP       | sampling the stop bit; good byte is handed to the holding reg
// WAIT_IDLE  | framing error seen, waiting for the line to return high
module uartcon_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rate_clk,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;

    localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             rxd_m;
    logic             rxd_s;
    logic             rate_m;
    logic             rate_s;
    logic             rate_d;
    logic             tick;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             deliver;

    // rxd idles high, so its synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_m  <= 1'b1;
            rxd_s  <= 1'b1;
            rate_m <= 1'b0;
            rate_s <= 1'b0;
            rate_d <= 1'b0;
        end else begin
            rxd_m  <= rxd;
            rxd_s  <= rxd_m;
            rate_m <= rate_clk;
            rate_s <= rate_m;
            rate_d <= rate_s;
        end
    end

    assign tick = rate_s & ~rate_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            deliver   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            deliver   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tick && !rxd_s) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (cnt == CNT_MID) begin
                            if (rxd_s) begin
                                state <= S_IDLE;
                            end else begin
                                cnt     <= '0;
                                bit_idx <= 3'd0;
                                state   <= S_DATA;
                            end
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (cnt == CNT_END) begin
                            shift[bit_idx] <= rxd_s;
                            cnt            <= '0;
                            if (bit_idx == 3'd7) begin
                                state <= S_STOP;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (cnt == CNT_END) begin
                            cnt <= '0;
                            if (rxd_s) begin
                                deliver <= 1'b1;
                                state   <= S_IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= S_WAIT_IDLE;
                            end
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (rxd_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // A delivery may reuse the slot that the consumer is draining in the same clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uartcon_rx.sv
// Scoreboard bench for uartcon_rx: stimulus pushes expected bytes, a monitor
// pops them on every accepted handshake and tallies error pulses.
module tb_uartcon_rx;

    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rate_clk = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int         total = 0;
    int         bad = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    logic [7:0] exp_q[$];
    bit         rand_ready = 0;

    uartcon_rx #(.OVERSAMPLE(16), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rate_clk  (rate_clk),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial forever #5 clk = ~clk;
    // Toggles on clk falling edges: one tick every 4 clk, 64 clk per bit.
    initial forever #20 rate_clk = ~rate_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    // Leaves rxd at the stop-bit level so a forced-low stop can run into a break.
    task automatic send_frame(input logic [7:0] d, input logic stop, input bit expect_byte);
        if (expect_byte) exp_q.push_back(d);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    always @(negedge clk) begin
        if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
    end

    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 32'(rx_valid), 32'd1);
                check("hold_data", 32'(rx_data), 32'(prev_data));
            end
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got %0h expected none", rx_data);
                end else begin
                    check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
                end
            end
            if (frame_err && overrun) begin
                total++;
                bad++;
                $display("FAIL err_overlap: got frame_err=1 overrun=1 expected not both");
            end
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            prev_hold = rx_valid && !rx_ready;
            prev_data = rx_data;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  fe0;
        int  ov0;
        int  n;
        bit  seen;
        logic [7:0] r;

        @(negedge clk);
        idle_clk(5);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        idle_clk(20);

        // Plain frame with the consumer always ready.
        rx_ready = 1'b1;
        fe0 = fe_cnt;
        send_frame(8'hA5, 1'b1, 1);
        idle_clk(20);
        check("a5_busy_done", 32'(busy), 32'd0);
        check("a5_fe", 32'(fe_cnt - fe0), 32'd0);
        check("a5_drained", 32'(exp_q.size()), 32'd0);

        // Short low pulse is rejected at mid start bit.
        rxd = 1'b0;
        idle_clk(12);
        check("glitch_seen", 32'(busy), 32'd1);
        idle_clk(4);
        rxd = 1'b1;
        idle_clk(60);
        check("glitch_idle", 32'(busy), 32'd0);
        check("glitch_fe", 32'(fe_cnt - fe0), 32'd0);

        // Bad stop bit followed by a held break: one frame_err only.
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 0);
        idle_clk(400);
        check("break_wait_busy", 32'(busy), 32'd1);
        check("break_fe_once", 32'(fe_cnt - fe0), 32'd1);
        rxd = 1'b1;
        idle_clk(10);
        check("break_released", 32'(busy), 32'd0);
        idle_clk(50);
        send_frame(8'h81, 1'b1, 1);
        idle_clk(20);
        check("after_break_drained", 32'(exp_q.size()), 32'd0);

        // Overrun: second byte arrives while the first is still held.
        rx_ready = 1'b0;
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, 1);
        idle_clk(20);
        send_frame(8'h22, 1'b1, 0);
        idle_clk(20);
        check("ovr_valid", 32'(rx_valid), 32'd1);
        check("ovr_data", 32'(rx_data), 32'h11);
        check("ovr_pulse", 32'(ov_cnt - ov0), 32'd1);
        rx_ready = 1'b1;
        idle_clk(3);
        check("ovr_drain_valid", 32'(rx_valid), 32'd0);
        check("ovr_drained", 32'(exp_q.size()), 32'd0);

        // Accept of the held byte in the same clk the next byte is delivered.
        rx_ready = 1'b0;
        send_frame(8'h44, 1'b1, 1);
        idle_clk(20);
        check("sim_hold_data", 32'(rx_data), 32'h44);
        ov0 = ov_cnt;
        exp_q.push_back(8'h55);
        fork
            send_frame(8'h55, 1'b1, 0);
            begin
                seen = 0;
                n = 0;
                while (!busy && n < 200) begin @(negedge clk); n++; end
                if (busy) begin
                    n = 0;
                    while (busy && n < 800) begin @(negedge clk); n++; end
                    seen = !busy;
                end
                check("sim_busy_fall", 32'(seen), 32'd1);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        idle_clk(10);
        check("sim_valid", 32'(rx_valid), 32'd1);
        check("sim_data", 32'(rx_data), 32'h55);
        check("sim_no_overrun", 32'(ov_cnt - ov0), 32'd0);
        rx_ready = 1'b1;
        idle_clk(3);
        check("sim_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of data bit 4 of 0xF0.
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        idle_clk(20);
        r = 8'hF0;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(r[i]);
        rxd = r[4];
        idle_clk(32);
        check("rst_mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstm_rx_data", 32'(rx_data), 32'h00);
        check("rstm_rx_valid", 32'(rx_valid), 32'd0);
        check("rstm_busy", 32'(busy), 32'd0);
        check("rstm_err", 32'({frame_err, overrun}), 32'd0);
        @(negedge clk);
        idle_clk(5);
        rxd = 1'b1;
        rst_n = 1'b1;
        idle_clk(3 * BIT_CLK);
        send_frame(8'h0F, 1'b1, 1);
        idle_clk(30);
        check("rst_after_data", 32'(rx_data), 32'h0F);
        check("rst_after_drained", 32'(exp_q.size()), 32'd0);
        check("rst_no_flags", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);

        // Random bytes, random gaps, random backpressure well inside a frame time.
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rand_ready = 1;
        for (int k = 0; k < 8; k++) begin
            idle_clk(int'($urandom_range(1, 100)));
            send_frame(8'($urandom_range(0, 255)), 1'b1, 1);
        end
        idle_clk(30);
        rand_ready = 0;
        rx_ready = 1'b1;
        idle_clk(10);
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check("rand_no_flags", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uartcon_rx.md
Name: uartcon_rx

Overview:
- UART receive stage that consumes the divided oversample clock from the baud divider (uartcon_clk).
- Runs entirely in the clk domain. Rising edges of rate_clk are detected synchronously and used as oversample ticks. rate_clk is never used as a clock.
- Deframes 8N1 serial data from the rxd pin, LSB first.
- Presents each received byte on a one-entry valid/ready holding register, with framing-error and overrun flags.

Parameters:
- OVERSAMPLE, 16, oversample ticks per bit period. Must be even, 4..256.
- CNT_W, 8, tick counter width. Must satisfy 2^CNT_W >= OVERSAMPLE.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- rate_clk  input  1  oversample clock level from the baud divider; each rising edge is one tick
- rxd  input  1  serial receive line, idle high, asynchronous to clk
- rx_data  output  8  received byte, valid while rx_valid=1
- rx_valid  output  1  holding register full
- rx_ready  input  1  consumer accepts byte when rx_valid&&rx_ready
- frame_err  output  1  one-clk pulse: stop bit sampled 0
- overrun  output  1  one-clk pulse: byte completed while holding register full and not being accepted
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - All outputs reset to 0: rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - rxd synchronizer flops reset to 1; rate_clk synchronizer and edge flops reset to 0; FSM resets to IDLE.
- Input conditioning:
  - rxd passes through a 2-flop synchronizer; rxd_s is the second flop.
  - rate_clk passes through a 2-flop synchronizer plus one edge flop.
  - tick = 1 for exactly one clk when the synced rate_clk goes 0->1. Latency is 3 clk from rate_clk rise.
- The FSM advances only on tick cycles, except for WAIT_IDLE exit and the handshake logic, which act every clk.
- States and transitions:
  - IDLE: on a tick with rxd_s=0 -> START, cnt=0.
  - START: count ticks.
    - At the tick where cnt==OVERSAMPLE/2-1 (mid start bit): if rxd_s=1 -> IDLE (glitch rejected, no flag); else cnt=0, bit=0 -> DATA.
  - DATA: at the tick where cnt==OVERSAMPLE-1, sample rxd_s into shift[bit] (LSB first) and set cnt=0.
    - bit==7 -> STOP; otherwise bit++.
  - STOP: at the tick where cnt==OVERSAMPLE-1, sample rxd_s.
    - 1 -> deliver byte, go to IDLE.
    - 0 -> frame_err=1 for one clk, byte discarded, go to WAIT_IDLE.
  - WAIT_IDLE: any clk with rxd_s=1 -> IDLE. A held break therefore produces only one frame_err.
- Counters: cnt wraps to 0 at every sample point. Non-sample ticks increment cnt. bit is 3 bits.
- Delivery happens in the clk after the good stop sample:
  - Holding empty, or rx_valid&&rx_ready in that same clk: rx_data<=shift, rx_valid<=1.
  - Holding full and not accepted that clk: overrun=1 for one clk, new byte dropped, old rx_data/rx_valid unchanged.
- Handshake:
  - rx_valid stays high and rx_data stays stable until rx_valid&&rx_ready.
  - rx_valid clears in the following clk unless a simultaneous delivery reloads it.
  - rx_ready while rx_valid=0 has no effect.
- busy=1 in START, DATA, STOP and WAIT_IDLE.
- A start bit is sampled at its midpoint. Each data bit is sampled OVERSAMPLE ticks later, i.e. at bit centre, within one tick plus synchronizer latency.
- Reset mid-frame aborts immediately with no flags. After release, reception restarts only on the next falling edge seen in IDLE.
- A stop-bit sample coincides with no other FSM event. frame_err and overrun are never asserted in the same clk.

Test Plan:
- Bench stimulus: OVERSAMPLE=16; rate_clk toggles every 2 clk (tick every 4 clk, bit = 64 clk).
- Send 0xA5 (start 0; bits 1,0,1,0,0,1,0,1; stop 1), rx_ready=1 -> one rx_valid cycle with rx_data=8'hA5, frame_err=0, busy back to 0 after stop.
- rxd low pulse of 16 clk (< half bit), then high -> FSM returns to IDLE at mid-start, no rx_valid, no frame_err.
- Send 0x3C with stop bit forced 0, then rxd held low for 400 clk -> exactly one frame_err pulse, no rx_valid. Next frame 0x81 after rxd high is received correctly.
- rx_ready=0, send 0x11 then 0x22 -> rx_valid=1, rx_data=8'h11 held. overrun pulses once at 0x22 completion. Raising rx_ready then drains 0x11 and rx_valid=0.
- rx_ready asserted in the same clk that 0x55 completes while 0x44 is held -> 0x44 accepted, rx_data=8'h55, rx_valid stays 1, no overrun.
- Assert rst_n=0 during DATA bit 4 of 0xF0 -> all outputs 0 immediately. After release, a full 0x0F frame yields rx_data=8'h0F only.
